// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote sampling, per-frame error flags and an
// output FIFO with valid/ready handshake.
// Optional feature: define UART_RX_BREAK_DETECT_EN to drop all-zero framing-error
// frames as line breaks and pulse break_det instead of pushing them.
module uart_rx_fifo #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int unsigned BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF       = BIT_PERIOD / 2;
    localparam int unsigned TW         = $clog2(BIT_PERIOD);
    localparam int unsigned IW         = $clog2(DATA_BITS);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CW         = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    typedef struct packed {
        logic                 parity_err;
        logic                 frame_err;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    state_t state_q, state_d;

    logic                 rx_m, rx_s;
    logic                 s0_q, s1_q;
    logic [TW-1:0]        tmr_q;
    logic [IW-1:0]        idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 parity_err_q;
    logic                 frame_err_q;

    logic mid_c, end_c, maj_c, last_bit_c, last_stop_c, frame_err_fin_c;
    logic is_break_c, push_req_c, brk_c;

    // Bit-cell timing strobes and 3-sample majority vote
    always_comb begin
        mid_c           = (tmr_q == TW'(HALF + 1));
        end_c           = (tmr_q == TW'(BIT_PERIOD - 1));
        maj_c           = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
        last_bit_c      = (idx_q == IW'(DATA_BITS - 1));
        last_stop_c     = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;
        frame_err_fin_c = frame_err_q | ~maj_c;
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic par_bit_q;

    // Received parity bit, kept only to recognise a break
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            par_bit_q <= 1'b0;
        end else if (state_q == S_PARITY && mid_c) begin
            par_bit_q <= maj_c;
        end
    end

    assign is_break_c = (data_q == '0) && !par_bit_q && frame_err_fin_c;
`else
    assign is_break_c = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (!rx_s) state_d = S_START;
            S_START: begin
                if (mid_c && maj_c)  state_d = S_IDLE;
                else if (end_c)      state_d = S_DATA;
            end
            S_DATA:      if (end_c && last_bit_c) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (end_c) state_d = S_STOP;
            S_STOP:      if (mid_c && last_stop_c) state_d = frame_err_fin_c ? S_WAIT_HIGH : S_IDLE;
            S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // FSM outputs: frame completion decides push or break
    always_comb begin
        push_req_c = 1'b0;
        brk_c      = 1'b0;
        if (state_q == S_STOP && mid_c && last_stop_c) begin
            push_req_c = !is_break_c;
            brk_c      = is_break_c;
        end
    end

    // Synchroniser, sampling, bit timer and frame assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m         <= 1'b1;
            rx_s         <= 1'b1;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            tmr_q        <= '0;
            idx_q        <= '0;
            stop_idx_q   <= 1'b0;
            data_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            if (tmr_q == TW'(HALF - 1)) s0_q <= rx_s;
            if (tmr_q == TW'(HALF))     s1_q <= rx_s;

            if (state_q == S_IDLE || state_q == S_WAIT_HIGH || end_c) begin
                tmr_q <= '0;
            end else begin
                tmr_q <= tmr_q + TW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    idx_q        <= '0;
                    stop_idx_q   <= 1'b0;
                    parity_err_q <= 1'b0;
                    frame_err_q  <= 1'b0;
                end
                S_DATA: begin
                    if (mid_c) data_q <= {maj_c, data_q[DATA_BITS-1:1]};
                    if (end_c && !last_bit_c) idx_q <= idx_q + IW'(1);
                end
                S_PARITY: begin
                    if (mid_c) parity_err_q <= (PARITY == 1) ? ~(^data_q ^ maj_c) : (^data_q ^ maj_c);
                end
                S_STOP: begin
                    if (mid_c && !maj_c) frame_err_q <= 1'b1;
                    if (end_c)           stop_idx_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output FIFO
    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_c, full_c, push_c, ovf_c;
    entry_t        new_entry_c, head_d;

    // FIFO control and registered head-of-queue selection
    always_comb begin
        new_entry_c = '{parity_err: parity_err_q, frame_err: frame_err_fin_c, data: data_q};
        pop_c       = m_valid && m_ready;
        full_c      = (count_q == CW'(FIFO_DEPTH));
        push_c      = push_req_c && (!full_c || pop_c);
        ovf_c       = push_req_c && full_c && !pop_c;
        rd_ptr_d    = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push_c && !pop_c)      count_d = count_q + CW'(1);
        else if (!push_c && pop_c) count_d = count_q - CW'(1);
        head_d      = (push_c && wr_ptr_q == rd_ptr_d) ? new_entry_c : mem[rd_ptr_d];
    end

    // FIFO storage, pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            m_data       <= '0;
            m_parity_err <= 1'b0;
            m_frame_err  <= 1'b0;
            m_valid      <= 1'b0;
            overrun      <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            if (push_c) begin
                mem[wr_ptr_q] <= new_entry_c;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            m_data       <= head_d.data;
            m_parity_err <= head_d.parity_err;
            m_frame_err  <= head_d.frame_err;
            m_valid      <= (count_d != '0);
            overrun      <= ovf_c;
            break_det    <= brk_c;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with configurable frame format (5–9 data bits, none/odd/even parity, 1 or 2 stop bits), 3-sample majority-vote bit decision, per-frame error flags, and an output FIFO with valid/ready handshake. It sits between the board RX pin and any byte/word consumer in the design (e.g. weight/image loaders), replacing single-cycle `ready` strobes with a back-pressurable stream.

## Interface
- `CLOCK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate. `BIT_PERIOD = CLOCK_FREQ / BAUD_RATE` (integer divide); must be ≥ 8.
- `DATA_BITS`, default 8: data bits per frame, 5..9, LSB first.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: output FIFO entries; power of 2, ≥ 2.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx` in 1: serial line, asynchronous, idle high.
- `m_data` out DATA_BITS: head-of-FIFO data.
- `m_parity_err` out 1: head entry had a parity mismatch (always 0 when PARITY=0).
- `m_frame_err` out 1: head entry had a stop bit sampled 0.
- `m_valid` out 1: FIFO not empty.
- `m_ready` in 1: consumer accepts the head entry when `m_valid && m_ready`.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped because the FIFO is full.
- `break_det` out 1: one-cycle pulse on line break (see Configuration).

## Operation
- `rx` passes through a 2-FF synchroniser (reset to 1) → `rx_s`. All decisions use `rx_s`.
- Bit timer `tmr` counts 0..BIT_PERIOD-1 within each bit. `HALF = BIT_PERIOD/2`. `rx_s` is sampled at `tmr` = HALF-1, HALF, HALF+1; bit value = majority of the 3 samples, decided at HALF+1.
- States:
  - IDLE: on `rx_s == 0` → START, `tmr = 0`.
  - START: at HALF+1, majority 1 → IDLE (false start, nothing pushed). Otherwise at BIT_PERIOD-1 → DATA, `tmr = 0`, `idx = 0`.
  - DATA: bit `idx` stored at HALF+1; at BIT_PERIOD-1, `idx == DATA_BITS-1` → PARITY (if PARITY≠0) else STOP, otherwise `idx++`.
  - PARITY: sampled bit checked. Odd: XOR(data, p) must be 1; even: must be 0. Mismatch sets `parity_err`. → STOP at BIT_PERIOD-1.
  - STOP: any stop bit with majority 0 sets `frame_err`. With STOP_BITS=2, the first stop runs a full period. The last stop bit completes at HALF+1: frame pushed. → IDLE if no frame error, else WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s == 1`, then → IDLE. This prevents re-triggering on a held-low line.
- FIFO entry = {parity_err, frame_err, data}. Errored frames are still pushed.
- FIFO full at push and no pop in the same cycle: frame dropped, `overrun` pulses. A push and pop in the same cycle while full both succeed.
- Storage, pointers and count reset to 0, so after reset `m_data = 0` and both flags = 0.

## Timing
- Reset values: `m_valid = 0`, `m_data = 0`, `m_parity_err = 0`, `m_frame_err = 0`, `overrun = 0`, `break_det = 0`. FSM in IDLE, synchroniser at 1.
- `rx` falling edge → START entry: 2–3 clk (synchroniser).
- Push occurs at HALF+1 of the last stop bit. `m_valid` rises on the next clk; `m_data` is registered from storage.
- Pop: on `m_valid && m_ready` at posedge, the next entry (or `m_valid = 0`) appears after that edge.
- `overrun` and `break_det` are registered one-cycle pulses, aligned with the push cycle + 1.
- `rst_n` asserted mid-frame: immediate return to reset state, partial frame discarded, FIFO emptied. After release the FSM waits in IDLE for the next falling `rx_s`.

## Configuration
- `UART_RX_BREAK_DETECT_EN` defined: a frame with all data bits 0, parity bit (if any) 0, and frame_err set is a break.
  - Break: not pushed, `break_det` pulses, FSM → WAIT_HIGH.
- Not defined: `break_det` tied 0. Such a frame is pushed as data 0 with `m_frame_err = 1`.

## Test plan
All scenarios use CLOCK_FREQ=16_000_000 and BAUD_RATE=1_000_000 (BIT_PERIOD 16), with defaults unless stated.
- 8N1 frame 0xA5, `m_ready=1` → one `m_valid` cycle with `m_data = 0xA5`, both flags 0.
- PARITY=2, data 0x03 sent with parity bit 1 → `m_data = 0x03`, `m_parity_err = 1`. Same frame with parity bit 0 → `m_parity_err = 0`.
- `rx` low for 4 clk, then high → no push, FSM returns to IDLE. A following 0x3C frame is received correctly.
- FIFO_DEPTH=4, `m_ready=0`, send 0x01..0x05 → `overrun` pulses once on the 5th frame. Raising `m_ready` yields 0x01, 0x02, 0x03, 0x04, then `m_valid = 0`.
- Frame 0x55 with stop bit 0, then line held low 40 clk → one push with `m_frame_err = 1` and no further frames. Frame 0x00 with stop 0 → `break_det` pulse and no push with the macro; push of 0x00 with `m_frame_err = 1` without it.
- `rst_n` pulsed during data bit 4 of 0xFF → no push, all outputs 0. The next frame 0x81 is received correctly.
